// File: rtl/ota_pkg.sv
// Shared types and default sizing for the OTA bitstream decimator.
// Imported by the synchronizer and the decimator top.
package ota_pkg;

  typedef enum logic {
    IDLE,
    ACQ
  } ota_state_t;

  localparam int OTA_WINDOW_LOG2 = 8;
  localparam int OTA_OUT_W       = 8;
  localparam int OTA_SYNC_STAGES = 2;

endpackage

// File: rtl/ota_cmp_sync.sv
// Flop-chain synchronizer for an asynchronous 1-bit pin.
// Output is the input delayed STAGES clocks.
module ota_cmp_sync
  import ota_pkg::*;
#(
  parameter int STAGES = OTA_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the raw pin through the chain; reset clears every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ota_bitstream_decimator.sv
// Pulse-density decimator: counts ones over a fixed window of
// qualified comparator samples and hands out a saturated code.
module ota_bitstream_decimator
  import ota_pkg::*;
#(
  parameter int WINDOW_LOG2 = OTA_WINDOW_LOG2,
  parameter int OUT_W       = OTA_OUT_W,
  parameter int SYNC_STAGES = OTA_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmp_in,
  input  logic             sample_en,
  input  logic             start,
  input  logic             continuous,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CW    = WINDOW_LOG2 + 1;
  localparam int SHIFT = WINDOW_LOG2 - OUT_W;

  localparam logic [CW-1:0] FULL_C =
    {1'b1, {WINDOW_LOG2{1'b0}}};
  localparam logic [CW-1:0] MAX_C =
    {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [CW-1:0] ONE_C =
    {{WINDOW_LOG2{1'b0}}, 1'b1};

  ota_state_t state;
  ota_state_t state_n;

  logic            cmp_s;
  logic [CW-1:0]   sample_cnt;
  logic [CW-1:0]   ones_cnt;
  logic [CW-1:0]   shifted;
  logic [OUT_W-1:0] result;
  logic            launch;
  logic            win_full;
  logic            result_evt;

  ota_cmp_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (cmp_in),
    .q  (cmp_s)
  );

  // a full count is held for one cycle and converted on the next edge
  assign launch     = (state == IDLE) && en && start;
  assign win_full   = (state == ACQ) && (sample_cnt == FULL_C);
  assign result_evt = win_full && en;
  assign busy       = (state == ACQ);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state: enable low always wins, single-shot ends on full window
  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state_n = ACQ;
        ACQ:  if (win_full && !continuous) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // sample and ones counters; a continuous restart keeps this cycle's sample
  always_ff @(posedge clk) begin
    if (rst || !en || launch) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
    end else if (state == ACQ) begin
      if (win_full) begin
        if (continuous) begin
          sample_cnt <= {{WINDOW_LOG2{1'b0}}, sample_en};
          ones_cnt   <= {{WINDOW_LOG2{1'b0}}, sample_en & cmp_s};
        end else begin
          sample_cnt <= '0;
          ones_cnt   <= '0;
        end
      end else if (sample_en) begin
        sample_cnt <= sample_cnt + ONE_C;
        ones_cnt   <= ones_cnt + {{WINDOW_LOG2{1'b0}}, cmp_s};
      end
    end
  end

  // scale the window count to the code width, clamping the all-ones case
  always_comb begin
    shifted = ones_cnt >> SHIFT;
    result  = shifted[OUT_W-1:0];
    if (shifted > MAX_C) begin
      result = MAX_C[OUT_W-1:0];
    end
  end

  // output register with valid/ready hold and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (launch) begin
        overrun <= 1'b0;
      end
      if (result_evt) begin
        if (dout_valid && !dout_ready) begin
          overrun <= 1'b1;
        end else begin
          dout       <= result;
          dout_valid <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Directed-sequence bench for the OTA bitstream decimator with
// random comparator streams scored against a window-count model.
module tb_ota_bitstream_decimator;

  localparam int N = 16384;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cmp_in;
  logic       sample_en;
  logic       start;
  logic       continuous;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       overrun;

  bit cmp_a [N];
  bit se_a  [N];

  int cyc;
  int n_chk;
  int n_fail;

  ota_bitstream_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cmp_in    (cmp_in),
    .sample_en (sample_en),
    .start     (start),
    .continuous(continuous),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive stream inputs for index cyc; that edge captures them
  task automatic tick();
    cmp_in    = cmp_a[cyc];
    sample_en = se_a[cyc];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // cm: 0 zeros, 1 ones, 2 alternate, 3 one-in-four, 4 random
  // sm: 0 always qualified, 1 random ~50% qualified
  task automatic fill(input int from, input int len,
                      input int cm, input int sm);
    for (int i = from; i < from + len && i < N; i++) begin
      case (cm)
        0: cmp_a[i] = 1'b0;
        1: cmp_a[i] = 1'b1;
        2: cmp_a[i] = (i % 2) == 0;
        3: cmp_a[i] = (i % 4) == 0;
        default: cmp_a[i] = $urandom_range(1, 0) == 1;
      endcase
      se_a[i] = (sm == 0) ? 1'b1 : ($urandom_range(1, 0) == 1);
    end
  endtask

  // a window opened at edge s takes the next 256 qualified edges;
  // edge n sees the pin value driven two edges earlier
  task automatic model(input int s, output int code, output int last);
    int n;
    int c;
    int ones;
    n = s + 1;
    c = 0;
    ones = 0;
    last = s;
    while (c < 256 && n < N) begin
      if (se_a[n]) begin
        c++;
        ones += int'(cmp_a[n-2]);
        last = n;
      end
      n++;
    end
    code = (ones > 255) ? 255 : ones;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!dout_valid && k < 3000);
    chk({tag, "_seen"}, 32'(dout_valid), 32'd1);
  endtask

  task automatic do_single(input string tag, input int cm,
                           input int sm, output int lat);
    int s;
    int code;
    int last;
    fill(cyc, 1500, cm, sm);
    s = cyc;
    model(s, code, last);
    en = 1'b1;
    continuous = 1'b0;
    dout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ovr_clr"}, 32'(overrun), 32'd0);
    wait_valid(tag);
    lat = cyc - 1 - s;
    chk({tag, "_time"}, 32'(cyc), 32'(last + 2));
    chk({tag, "_dout"}, 32'(dout), 32'(code));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int s;
    int c1;
    int c2;
    int c3;
    int l1;
    int l2;
    int l3;
    int hits;

    cyc = 0;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < N; i++) begin
      cmp_a[i] = 1'b0;
      se_a[i]  = 1'b1;
    end
    rst = 1'b1;
    en = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    dout_ready = 1'b0;
    cmp_in = 1'b0;
    sample_en = 1'b0;

    repeat (3) tick();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    do_single("zero", 0, 0, lat);
    chk("zero_lat", 32'(lat), 32'd257);
    do_single("full", 1, 0, lat);
    chk("full_ovr", 32'(overrun), 32'd0);
    do_single("half", 2, 0, lat);
    do_single("quarter", 3, 0, lat);
    do_single("rand", 4, 0, lat);
    do_single("rand_duty", 4, 1, lat);

    // continuous, consumer always ready
    fill(cyc, 1500, 4, 0);
    s = cyc;
    model(s, c1, l1);
    model(l1, c2, l2);
    model(l2, c3, l3);
    en = 1'b1;
    continuous = 1'b1;
    dout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("cont1");
    chk("cont1_time", 32'(cyc), 32'(l1 + 2));
    chk("cont1_dout", 32'(dout), 32'(c1));
    wait_valid("cont2");
    chk("cont2_time", 32'(cyc), 32'(l2 + 2));
    chk("cont2_dout", 32'(dout), 32'(c2));
    wait_valid("cont3");
    chk("cont3_time", 32'(cyc), 32'(l3 + 2));
    chk("cont3_dout", 32'(dout), 32'(c3));
    chk("cont_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick();
    chk("cont_stop", 32'(busy), 32'd0);
    continuous = 1'b0;

    // overrun: consumer stalled across two windows
    fill(cyc, 1500, 4, 0);
    s = cyc;
    model(s, c1, l1);
    model(l1, c2, l2);
    en = 1'b1;
    continuous = 1'b1;
    dout_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("ovr1");
    chk("ovr1_time", 32'(cyc), 32'(l1 + 2));
    chk("ovr1_dout", 32'(dout), 32'(c1));
    chk("ovr1_flag", 32'(overrun), 32'd0);
    while (cyc < l2 + 1) tick();
    chk("ovr_pre", 32'(overrun), 32'd0);
    tick();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_hold", 32'(dout), 32'(c1));
    chk("ovr_valid", 32'(dout_valid), 32'd1);
    en = 1'b0;
    dout_ready = 1'b1;
    tick();
    chk("ovr_xfer", 32'(dout_valid), 32'd0);
    tick();
    chk("ovr_once", 32'(dout_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    continuous = 1'b0;

    // abort at sample 100, then a clean full window
    fill(cyc, 600, 4, 0);
    en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_ovr_clr", 32'(overrun), 32'd0);
    repeat (99) tick();
    en = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(dout_valid), 32'd0);
    en = 1'b1;
    hits = 0;
    repeat (300) begin
      tick();
      if (dout_valid) hits++;
    end
    chk("abort_quiet", 32'(hits), 32'd0);
    do_single("after_abort", 4, 0, lat);
    chk("after_abort_lat", 32'(lat), 32'd257);

    // reset mid-window with a 50% qualifier, then restart
    fill(cyc, 400, 4, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    chk("mrst_dout", 32'(dout), 32'd0);
    chk("mrst_valid", 32'(dout_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    do_single("mrst_duty", 4, 1, lat);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
